chip_595_chain: RTL and testbench
=================================

CHIP_595_CHAIN -- requirements
Module: chip_595_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bits per cascaded stage.
REQ-002 The block SHALL have parameter STAGES, default 2: number of cascaded 595-style stages. N = WIDTH*STAGES.
REQ-003 The block SHALL have parameter LSB_FIRST, default 0: 0 shifts toward bit N-1, 1 shifts toward bit 0.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on SRCLK, RCLK, SER and SRCLRn, minimum 2.
REQ-005 CLK input 1: the single system clock, sampled on its rising edge.
REQ-006 RSTn input 1: reset, asynchronous, active-low.
REQ-007 OEn input 1: output enable, active-low, combinational to Q.
REQ-008 RCLK input 1: storage register strobe, synchronized to CLK.
REQ-009 SRCLK input 1: shift strobe, synchronized to CLK.
REQ-010 SRCLRn input 1: shift register clear, active-low, level-sensitive.
REQ-011 SER input 1: serial data in.
REQ-012 Q output N: parallel storage output.
REQ-013 QH output 1: serial cascade output.
REQ-014 SHIFT_CNT output $clog2(N+1): number of shifts since the last latch or clear.
REQ-015 FRAME_ERR output 1: sticky flag for a latch with SHIFT_CNT != N.

Function
REQ-016 SRCLK, RCLK, SER and SRCLRn SHALL pass through identical SYNC_STAGES-deep synchronizers so they stay mutually aligned.
REQ-017 A shift event SHALL be a 0->1 transition of synchronized SRCLK; a latch event SHALL be a 0->1 transition of synchronized RCLK.
REQ-018 Latency from the first CLK edge that samples an SRCLK/RCLK rise to the register update SHALL be exactly SYNC_STAGES+1 CLK cycles.
REQ-019 Inputs held for fewer than 2 CLK cycles per level are unsupported; the block need not detect such pulses.
REQ-020 On a shift event with LSB_FIRST=0, sr SHALL become {sr[N-2:0], SER_sync}; with LSB_FIRST=1, sr SHALL become {SER_sync, sr[N-1:1]}.
REQ-021 While synchronized SRCLRn is 0, sr SHALL be cleared every CLK cycle, SHIFT_CNT SHALL be 0, and shift events SHALL be ignored.
REQ-022 On a latch event, storage SHALL take sr's value from before any same-cycle shift or clear.
REQ-023 Q SHALL equal storage when OEn=0 and SHALL be all 'z' when OEn=1.
REQ-024 QH SHALL be sr[N-1] when LSB_FIRST=0 and sr[0] when LSB_FIRST=1 (shift register, not storage), independent of OEn.
REQ-025 SHIFT_CNT SHALL increment on each shift event and saturate at N.
REQ-026 On a latch event, SHIFT_CNT SHALL be set to 1 if a shift occurs in the same cycle, otherwise to 0.
REQ-027 FRAME_ERR SHALL be set on a latch event when the pre-latch SHIFT_CNT != N; only reset clears it.

Reset
REQ-028 RSTn=0 SHALL asynchronously clear all synchronizer flops, sr, storage, SHIFT_CNT and FRAME_ERR.
REQ-029 After reset, Q SHALL be 0 with OEn=0, and QH SHALL be 0.
REQ-030 Edge detectors SHALL treat the first post-reset synchronized level as the prior value, so a strobe already high at reset release is not an event.
REQ-031 Reset mid-frame SHALL discard partial shifts with no latch.

Structure
REQ-032 Parameter-derived constants (N, count width) SHALL be localparams in the module; no shared package is required.
REQ-033 One sub-module, chip_edge_sync (synchronizer plus rising-edge pulse, parameter SYNC_STAGES), SHALL be instantiated for SRCLK and RCLK.
REQ-034 SER and SRCLRn SHALL use matched-depth plain synchronizers.

Verification (WIDTH=8, STAGES=2, LSB_FIRST=0)
REQ-035 Shift 16 bits of 0xA5C3 MSB first, then pulse RCLK, OEn=0 -> Q=0xA5C3, SHIFT_CNT 16->0, FRAME_ERR=0.
REQ-036 Shift 12 bits then pulse RCLK -> FRAME_ERR=1 and stays 1 after further correct frames until RSTn=0.
REQ-037 SRCLK and RCLK rise in the same CLK cycle after sr=0x00FF, SER=1 -> storage=0x00FF, sr=0x01FF, SHIFT_CNT=1.
REQ-038 Hold SRCLRn=0 for 4 cycles while toggling SRCLK -> sr=0, QH=0, SHIFT_CNT=0; Q unchanged.
REQ-039 OEn=1 -> Q all 'z'; OEn=0 -> Q=storage in the same cycle; QH unaffected by OEn.
REQ-040 Assert RSTn=0 after 5 shifts, then release with SRCLK held high -> all outputs 0 and no shift event until SRCLK falls and rises again.

Source files
------------

// File: rtl/chip_595_chain_pkg.sv
// Shared constants and helpers for the 595-style cascaded shift/storage register.
package chip_595_chain_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;

    // Requested synchronizer depths below the metastability floor are raised to it.
    function automatic int unsigned sync_depth(input int unsigned requested);
        return (requested < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : requested;
    endfunction

endpackage

// File: rtl/chip_595_chain_if.sv
// Strobe/data inputs and status outputs of chip_595_chain grouped as one bundle.
interface chip_595_chain_if #(
    parameter int N = 16
) ();
    localparam int CW = $clog2(N + 1);

    logic          oen;
    logic          rclk;
    logic          srclk;
    logic          srclrn;
    logic          ser;
    logic          qh;
    logic [CW-1:0] shift_cnt;
    logic          frame_err;

    modport master (
        output oen, rclk, srclk, srclrn, ser,
        input  qh, shift_cnt, frame_err
    );

    modport slave (
        input  oen, rclk, srclk, srclrn, ser,
        output qh, shift_cnt, frame_err
    );

endinterface

// File: rtl/chip_edge_sync.sv
// Multi-flop synchronizer with a registered rising-edge pulse on the synchronized level.
module chip_edge_sync
    import chip_595_chain_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);
    localparam int DEPTH = sync_depth(SYNC_STAGES);
    localparam int WARM  = DEPTH + 1;
    localparam int WW    = $clog2(WARM + 1);

    logic [DEPTH-1:0] sync_q;
    logic             prev_q;
    logic             rise_q;
    logic [WW-1:0]    warm_q;
    logic             armed;

    // Edges are only trusted once prev_q holds a real post-reset sample, so a
    // strobe already high when reset releases never looks like a rise.
    assign armed = (warm_q == WW'(WARM));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
            prev_q <= sync_q[DEPTH-1];
            rise_q <= armed & sync_q[DEPTH-1] & ~prev_q;
            if (!armed) begin
                warm_q <= warm_q + 1'b1;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/chip_595_chain.sv
// Cascaded 595-style serial-in shift register with parallel storage, clocked from one system clock.
module chip_595_chain
    import chip_595_chain_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STAGES      = 2,
    parameter int LSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                CLK,
    input  logic                                RSTn,
    input  logic                                OEn,
    input  logic                                RCLK,
    input  logic                                SRCLK,
    input  logic                                SRCLRn,
    input  logic                                SER,
    output wire  [WIDTH*STAGES-1:0]             Q,
    output logic                                QH,
    output logic [$clog2(WIDTH*STAGES+1)-1:0]   SHIFT_CNT,
    output logic                                FRAME_ERR
);
    localparam int N     = WIDTH * STAGES;
    localparam int CW    = $clog2(N + 1);
    localparam int DEPTH = sync_depth(SYNC_STAGES);

    logic            srclk_rise;
    logic            rclk_rise;
    // One stage deeper than the strobe synchronizers to match their pulse register.
    logic [DEPTH:0][1:0] dsync_q;
    logic            ser_s;
    logic            clr_n_s;
    logic            shift_ev;

    logic [N-1:0]    sr_q, sr_d, sr_shift;
    logic [N-1:0]    st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ferr_q, ferr_d;

    chip_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_srclk_sync (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .d_i    (SRCLK),
        .rise_o (srclk_rise)
    );

    chip_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rclk_sync (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .d_i    (RCLK),
        .rise_o (rclk_rise)
    );

    assign ser_s    = dsync_q[DEPTH][1];
    assign clr_n_s  = dsync_q[DEPTH][0];
    assign shift_ev = srclk_rise & clr_n_s;

    always_comb begin
        if (LSB_FIRST != 0) begin
            sr_shift = {ser_s, sr_q[N-1:1]};
        end else begin
            sr_shift = {sr_q[N-2:0], ser_s};
        end

        sr_d   = sr_q;
        st_d   = st_q;
        cnt_d  = cnt_q;
        ferr_d = ferr_q;

        // Storage captures sr as it stood before this cycle's shift or clear.
        if (rclk_rise) begin
            st_d   = sr_q;
            ferr_d = ferr_q | (cnt_q != CW'(N));
        end

        if (!clr_n_s) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (rclk_rise) begin
            cnt_d = shift_ev ? CW'(1) : '0;
            if (shift_ev) begin
                sr_d = sr_shift;
            end
        end else if (shift_ev) begin
            sr_d = sr_shift;
            if (cnt_q != CW'(N)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dsync_q <= '0;
            sr_q    <= '0;
            st_q    <= '0;
            cnt_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            dsync_q <= {dsync_q[DEPTH-1:0], {SER, SRCLRn}};
            sr_q    <= sr_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
        end
    end

    assign Q         = OEn ? {N{1'bz}} : st_q;
    assign QH        = (LSB_FIRST != 0) ? sr_q[0] : sr_q[N-1];
    assign SHIFT_CNT = cnt_q;
    assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_chip_595_chain.sv
// Self-checking bench for chip_595_chain: frame table, corner sequences and random frames against a model.
module tb_chip_595_chain;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int N      = WIDTH * STAGES;
    localparam int CW     = $clog2(N + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    chip_595_chain_if #(.N(N)) bus ();
    wire [N-1:0] q_w;

    chip_595_chain #(
        .WIDTH(WIDTH), .STAGES(STAGES), .LSB_FIRST(0), .SYNC_STAGES(2)
    ) dut (
        .CLK       (clk),
        .RSTn      (rst_n),
        .OEn       (bus.oen),
        .RCLK      (bus.rclk),
        .SRCLK     (bus.srclk),
        .SRCLRn    (bus.srclrn),
        .SER       (bus.ser),
        .Q         (q_w),
        .QH        (bus.qh),
        .SHIFT_CNT (bus.shift_cnt),
        .FRAME_ERR (bus.frame_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int unsigned  n_total = 0;
    int unsigned  n_pass  = 0;
    logic [N-1:0] m_sr, m_st;
    int           m_cnt;
    bit           m_ferr;
    logic [N-1:0] exp_q[$];

    task automatic model_reset();
        m_sr = '0; m_st = '0; m_cnt = 0; m_ferr = 1'b0;
    endtask

    task automatic model_shift(input bit b);
        m_sr  = (m_sr << 1) | N'(b);
        m_cnt = (m_cnt < N) ? m_cnt + 1 : N;
    endtask

    task automatic model_latch();
        if (m_cnt != N) m_ferr = 1'b1;
        m_st  = m_sr;
        m_cnt = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_q"},    32'(q_w), 32'(m_st));
        check({tag, "_qh"},   32'(bus.qh), 32'((m_sr >> (N - 1)) & 1));
        check({tag, "_cnt"},  32'(bus.shift_cnt), 32'(m_cnt));
        check({tag, "_ferr"}, 32'(bus.frame_err), 32'(m_ferr));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input bit b);
        bus.ser   = b;
        bus.srclk = 1'b1; tick(3);
        bus.srclk = 1'b0; tick(3);
        model_shift(b);
    endtask

    task automatic latch();
        bus.rclk = 1'b1; tick(3);
        bus.rclk = 1'b0; tick(3);
        model_latch();
    endtask

    task automatic clear_sr();
        bus.srclrn = 1'b0; tick(4);
        bus.srclrn = 1'b1; tick(4);
        m_sr = '0; m_cnt = 0;
    endtask

    // ---------------- frame table ----------------
    typedef struct {
        logic [N-1:0] data;
        int           nbits;
        logic [N-1:0] exp_q;
        logic         exp_ferr;
    } frame_t;

    frame_t tbl[4];

    initial begin
        logic ok;
        int   nb;

        tbl[0] = '{16'hA5C3, 16, 16'hA5C3, 1'b0};
        tbl[1] = '{16'h1234, 16, 16'h1234, 1'b0};
        tbl[2] = '{16'h0ABC, 12, 16'h4ABC, 1'b1};
        tbl[3] = '{16'hFFFF, 16, 16'hFFFF, 1'b1};

        bus.oen = 1'b0; bus.rclk = 1'b0; bus.srclk = 1'b0;
        bus.srclrn = 1'b1; bus.ser = 1'b0;
        model_reset();

        // Reset state
        tick(2);
        check("rst_q", 32'(q_w), 32'h0);
        check("rst_qh", 32'(bus.qh), 32'h0);
        check("rst_cnt", 32'(bus.shift_cnt), 32'h0);
        check("rst_ferr", 32'(bus.frame_err), 32'h0);
        rst_n = 1'b1;
        tick(6);

        // Table-driven frames, MSB first
        for (int i = 0; i < 4; i++) begin
            for (int b = tbl[i].nbits - 1; b >= 0; b--) shift_bit(tbl[i].data[b]);
            check("tbl_cnt_pre", 32'(bus.shift_cnt), 32'((tbl[i].nbits > N) ? N : tbl[i].nbits));
            check("tbl_qh_pre", 32'(bus.qh), 32'(tbl[i].exp_q[N-1]));
            latch();
            check("tbl_q", 32'(q_w), 32'(tbl[i].exp_q));
            check("tbl_cnt_post", 32'(bus.shift_cnt), 32'h0);
            check("tbl_ferr", 32'(bus.frame_err), 32'(tbl[i].exp_ferr));
        end

        // Shift and latch in the same cycle
        clear_sr();
        for (int i = 0; i < 8; i++) shift_bit(1'b1);
        bus.ser = 1'b1; bus.srclk = 1'b1; bus.rclk = 1'b1; tick(3);
        bus.srclk = 1'b0; bus.rclk = 1'b0; tick(3);
        if (m_cnt != N) m_ferr = 1'b1;
        m_st = m_sr;
        m_sr = (m_sr << 1) | N'(1);
        m_cnt = 1;
        check("same_q", 32'(q_w), 32'h00FF);
        check("same_cnt", 32'(bus.shift_cnt), 32'd1);
        check("same_qh", 32'(bus.qh), 32'h0);
        for (int i = 0; i < 7; i++) shift_bit(1'b0);
        latch();
        check("same_sr_latched", 32'(q_w), 32'hFF80);
        check_model("same");

        // Output enable is combinational; QH ignores it
        for (int i = 0; i < 16; i++) shift_bit(1'b1);
        latch();
        shift_bit(1'b1); shift_bit(1'b1);
        bus.oen = 1'b1; #1;
        // A released bus reads as z, or as 0 on a two-state simulator.
        ok = (q_w === {N{1'bz}}) || (q_w === {N{1'b0}});
        check("oen_hiz", 32'(ok), 32'h1);
        check("oen_qh", 32'(bus.qh), 32'h1);
        bus.oen = 1'b0; #1;
        check("oen_q", 32'(q_w), 32'hFFFF);
        tick(1);

        // Clear held 4 cycles while SRCLK toggles
        bus.srclrn = 1'b0; bus.srclk = 1'b1; tick(2);
        bus.srclk = 1'b0; tick(2);
        bus.srclrn = 1'b1; tick(5);
        m_sr = '0; m_cnt = 0;
        check("clr_qh", 32'(bus.qh), 32'h0);
        check("clr_cnt", 32'(bus.shift_cnt), 32'h0);
        check("clr_q", 32'(q_w), 32'hFFFF);

        // Reset mid-frame, released with SRCLK high
        for (int i = 0; i < 5; i++) shift_bit(1'($urandom_range(0, 1)) | 1'b1);
        bus.ser = 1'b1; bus.srclk = 1'b1; tick(1);
        rst_n = 1'b0; #1;
        model_reset();
        check_model("rst_async");
        tick(3);
        rst_n = 1'b1;
        tick(10);
        check("rst_hi_cnt", 32'(bus.shift_cnt), 32'h0);
        check("rst_hi_qh", 32'(bus.qh), 32'h0);
        bus.srclk = 1'b0; tick(3);
        bus.srclk = 1'b1; tick(3);
        bus.srclk = 1'b0; tick(3);
        model_shift(1'b1);
        check("rst_rearm_cnt", 32'(bus.shift_cnt), 32'd1);

        // Random frames against the model
        for (int f = 0; f < 10; f++) begin
            if ($urandom_range(0, 4) == 0) clear_sr();
            nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : N;
            for (int i = 0; i < nb; i++) shift_bit(1'($urandom_range(0, 1)));
            check("rnd_cnt_pre", 32'(bus.shift_cnt), 32'(m_cnt));
            latch();
            exp_q.push_back(m_st);
            check("rnd_q", 32'(q_w), 32'(exp_q.pop_front()));
            check_model("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
